// File: rtl/note_prefetch_queue.sv
// note_prefetch_queue: streams one lane's note times from the chart RAM into a
// small FIFO. The matcher sees the head time (all 1's when nothing is buffered)
// and pops one entry per note_request pulse.
module note_prefetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int TIME_W = 18,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [TIME_W-1:0] rom_data,
    input  logic              note_request,
    output logic [TIME_W-1:0] note_time,
    output logic              note_valid,
    output logic              chart_done,
    output logic              order_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 2;
    localparam logic [TIME_W-1:0] ALL_ONES = {TIME_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [TIME_W-1:0]   last_q, last_d;
    logic                order_err_q, order_err_d;
    logic [TIME_W-1:0]   head_q, head_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [TIME_W-1:0]   mem_q [DEPTH];

    logic [OCC_W-1:0]    inflight_s;
    logic [OCC_W-1:0]    occ_s;
    logic                ret_valid_s;
    logic                marker_s;
    logic                push_s;
    logic                pop_s;
    logic                rom_en_s;
    logic [CNT_W-1:0]    after_pop_s;

    // Handshake decode: reads in flight, read issue, push and pop qualifiers.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + OCC_W'(vpipe_q[i]);
        end
        occ_s       = OCC_W'(count_q) + inflight_s;
        ret_valid_s = vpipe_q[RD_LAT-1];
        marker_s    = (state_q == ST_FETCH) && ret_valid_s && (rom_data == ALL_ONES);
        push_s      = !start && (state_q == ST_FETCH) && ret_valid_s && (rom_data != ALL_ONES);
        pop_s       = !start && note_request && (count_q != {CNT_W{1'b0}});
        // A read issued alongside the returning end marker would only be discarded.
        rom_en_s    = !start && (state_q == ST_FETCH) && !marker_s &&
                      (occ_s < OCC_W'(DEPTH));
    end

    // Datapath next state: pointers, occupancy, ordering check, start flush.
    always_comb begin
        vpipe_d[0] = rom_en_s;
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
        addr_d      = rom_en_s ? (addr_q + {{(ADDR_W-1){1'b0}}, 1'b1}) : addr_q;
        wr_ptr_d    = push_s ? (wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_q;
        last_d      = push_s ? rom_data : last_q;
        order_err_d = order_err_q | (push_s && (rom_data < last_q));
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        // start wins over everything: old returns and any same-cycle pop are dropped.
        if (start) begin
            vpipe_d     = '0;
            addr_d      = base_addr;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            last_d      = '0;
            order_err_d = 1'b0;
            count_d     = '0;
        end else begin
            vpipe_d     = vpipe_d;
        end
    end

    // Head register: bypass the RAM write when pushing into a queue that is empty after the pop.
    always_comb begin
        after_pop_s = count_q - CNT_W'(pop_s);
        if (count_d == {CNT_W{1'b0}}) begin
            valid_d = 1'b0;
            head_d  = ALL_ONES;
        end else if (push_s && (after_pop_s == {CNT_W{1'b0}})) begin
            valid_d = 1'b1;
            head_d  = rom_data;
        end else begin
            valid_d = 1'b1;
            head_d  = mem_q[rd_ptr_d];
        end
    end

    // FSM next state: fetch until the end marker, drain, then report done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_FETCH: state_d = marker_s ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: state_d = (count_d == {CNT_W{1'b0}}) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_FETCH;
        end else begin
            state_d = state_d;
        end
        done_d = (state_d == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Datapath registers; reset discards the in-flight pipe like start does.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            vpipe_q     <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            last_q      <= '0;
            order_err_q <= 1'b0;
            head_q      <= ALL_ONES;
            valid_q     <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            vpipe_q     <= vpipe_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            last_q      <= last_d;
            order_err_q <= order_err_d;
            head_q      <= head_d;
            valid_q     <= valid_d;
        end
    end

    // FIFO storage write; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rom_data;
        end
    end

    assign rom_addr    = addr_q;
    assign rom_en      = rom_en_s;
    assign note_time   = head_q;
    assign note_valid  = valid_q;
    assign chart_done  = done_q;
    assign order_error = order_err_q;

endmodule

// File: tb/tb_note_prefetch_queue.sv
// Testbench for note_prefetch_queue: chart RAM model with 2-cycle latency,
// scoreboard of expected note times checked by a monitor on every accepted pop.
module tb_note_prefetch_queue;

    localparam int ADDR_W = 12;
    localparam int TIME_W = 18;
    localparam logic [TIME_W-1:0] ONES = {TIME_W{1'b1}};

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [TIME_W-1:0] rom_data;
    logic              note_request;
    logic [TIME_W-1:0] note_time;
    logic              note_valid;
    logic              chart_done;
    logic              order_error;

    logic [TIME_W-1:0] rom [0:4095];
    logic [TIME_W-1:0] d1 = '0;
    logic [TIME_W-1:0] d2 = '0;
    logic [TIME_W-1:0] exp_q [$];
    int total = 0;
    int fails = 0;

    note_prefetch_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .TIME_W(TIME_W), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .note_request(note_request), .note_time(note_time), .note_valid(note_valid),
        .chart_done(chart_done), .order_error(order_error)
    );

    always #5 clk = ~clk;

    // Chart RAM model: data appears two cycles after the rom_en cycle.
    always @(posedge clk) begin
        if (rom_en) d1 <= rom[rom_addr];
        d2 <= d1;
    end
    assign rom_data = d2;

    // Monitor: every accepted pop must deliver the next expected note time.
    always @(negedge clk) begin
        if (!reset && !start && note_request && note_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got 0x%0h required nothing", note_time);
            end else begin
                logic [TIME_W-1:0] e;
                e = exp_q.pop_front();
                if (note_time !== e) begin
                    fails++;
                    $display("FAIL sb_note: got 0x%0h required 0x%0h", note_time, e);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ens;
        int run;
        int bad;
        for (int i = 0; i < 4096; i++) rom[i] = '0;
        rom[12'h010] = 18'd100; rom[12'h011] = 18'd250; rom[12'h012] = 18'd400; rom[12'h013] = ONES;
        for (int i = 0; i < 10; i++) rom[12'h100 + i] = 18'(1000 + i);
        rom[12'h10A] = ONES;
        rom[12'h200] = 18'd500; rom[12'h201] = 18'd300; rom[12'h202] = ONES;
        for (int i = 0; i < 4; i++) rom[12'h300 + i] = 18'(11 + i);
        rom[12'h304] = ONES;
        rom[12'h020] = 18'd7; rom[12'h021] = ONES;

        reset = 1'b1; start = 1'b0; base_addr = '0; note_request = 1'b0;
        repeat (3) step;
        @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_note_time", 32'(note_time), 32'(ONES));
        chk("rst_note_valid", 32'(note_valid), 32'h0);
        chk("rst_chart_done", 32'(chart_done), 32'h0);
        chk("rst_order_error", 32'(order_error), 32'h0);
        step; reset = 1'b0;

        // Short chart: four reads, then head 100 at cycle 4.
        exp_q.push_back(18'd100); exp_q.push_back(18'd250); exp_q.push_back(18'd400);
        step; start = 1'b1; base_addr = 12'h010;
        step; start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("t1_rom_en", 32'(rom_en), 32'h1);
                chk("t1_rom_addr", 32'(rom_addr), 32'(12'h010 + c - 1));
            end else begin
                chk("t1_rom_en_off", 32'(rom_en), 32'h0);
            end
            if (c == 3) chk("t1_valid_c3", 32'(note_valid), 32'h0);
            if (c == 4) begin
                chk("t1_valid_c4", 32'(note_valid), 32'h1);
                chk("t1_time_c4", 32'(note_time), 32'd100);
            end
            step;
        end
        note_request = 1'b1; step; note_request = 1'b0; step;
        note_request = 1'b1; step; note_request = 1'b0;
        @(negedge clk);
        chk("t1_time_400", 32'(note_time), 32'd400);
        chk("t1_not_done", 32'(chart_done), 32'h0);
        step; note_request = 1'b1; step; note_request = 1'b0;
        @(negedge clk);
        chk("t1_empty_valid", 32'(note_valid), 32'h0);
        chk("t1_empty_time", 32'(note_time), 32'(ONES));
        chk("t1_done", 32'(chart_done), 32'h1);

        // Long chart without pops: exactly four reads, then one per pop.
        for (int i = 0; i < 10; i++) exp_q.push_back(18'(1000 + i));
        step; start = 1'b1; base_addr = 12'h100;
        step; start = 1'b0;
        ens = 0;
        repeat (12) begin @(negedge clk); if (rom_en) ens++; step; end
        chk("t2_en_count", 32'(ens), 32'd4);
        chk("t2_valid", 32'(note_valid), 32'h1);
        chk("t2_head", 32'(note_time), 32'd1000);
        note_request = 1'b1; step; note_request = 1'b0;
        ens = 0;
        repeat (6) begin
            @(negedge clk);
            if (rom_en) begin ens++; chk("t2_reissue_addr", 32'(rom_addr), 32'h104); end
            step;
        end
        chk("t2_reissue_count", 32'(ens), 32'd1);
        // Streaming: pop every cycle.
        note_request = 1'b1;
        run = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!note_valid) break;
            run++;
            step;
        end
        chk("t2_stream_run", 32'(run), 32'd9);
        step; note_request = 1'b0;
        @(negedge clk);
        chk("t2_done", 32'(chart_done), 32'h1);
        chk("t2_empty_time", 32'(note_time), 32'(ONES));

        // Out-of-order chart.
        exp_q.push_back(18'd500); exp_q.push_back(18'd300);
        step; start = 1'b1; base_addr = 12'h200;
        step; start = 1'b0;
        step; step;
        @(negedge clk); chk("t3_oe_c3", 32'(order_error), 32'h0);
        step; @(negedge clk); chk("t3_oe_c4", 32'(order_error), 32'h0);
        step; @(negedge clk); chk("t3_oe_c5", 32'(order_error), 32'h1);
        step; note_request = 1'b1;
        run = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!note_valid) break;
            run++;
            step;
        end
        chk("t3_delivered", 32'(run), 32'd2);
        step; note_request = 1'b0;
        @(negedge clk); chk("t3_oe_sticky", 32'(order_error), 32'h1);

        // Restart while old reads are in flight.
        step; start = 1'b1; base_addr = 12'h300;
        step; start = 1'b0;
        step; start = 1'b1; base_addr = 12'h020; exp_q.push_back(18'd7);
        step; start = 1'b0;
        run = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (note_valid) break;
            run++;
            step;
        end
        chk("t4_wait_bound", 32'(run < 10), 32'h1);
        chk("t4_first_time", 32'(note_time), 32'd7);
        chk("t4_oe_cleared", 32'(order_error), 32'h0);
        step; note_request = 1'b1;
        step; note_request = 1'b0;
        @(negedge clk);
        chk("t4_empty_valid", 32'(note_valid), 32'h0);
        chk("t4_empty_time", 32'(note_time), 32'(ONES));
        step; note_request = 1'b1;
        step; note_request = 1'b0;
        @(negedge clk);
        chk("t4_underflow_valid", 32'(note_valid), 32'h0);
        chk("t4_underflow_time", 32'(note_time), 32'(ONES));
        chk("t4_done", 32'(chart_done), 32'h1);
        repeat (3) step;
        @(negedge clk);
        chk("t4_still_empty", 32'(note_valid), 32'h0);

        // Reset mid-fetch: IDLE, no reads, nothing buffered.
        step; start = 1'b1; base_addr = 12'h100;
        step; start = 1'b0;
        step; reset = 1'b1;
        step; reset = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rom_en || note_valid || chart_done) bad++;
            step;
        end
        chk("t5_reset_idle", 32'(bad), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
